// File: rtl/mem_stage_bus.sv
// MEM stage with a req/ack data-memory bus master, byte-lane stores, extended loads and MEM/WB register.
// Optional watchdog abort of stuck transactions is enabled with `define MEM_TIMEOUT_EN.
module mem_stage_bus #(
    parameter int NB_DATA        = 32,
    parameter int NB_ADDR        = 8,
    parameter int NB_REG         = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic                 i_halt,
    input  logic [NB_DATA-1:0]   i_result,
    input  logic [NB_DATA-1:0]   i_data4Mem,
    input  logic [NB_REG-1:0]    i_reg2write,
    input  logic [1:0]           i_width,
    input  logic                 i_sign_flag,
    input  logic                 i_memRead,
    input  logic                 i_memWrite,
    input  logic                 i_mem2reg,
    input  logic                 i_regWrite,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic [NB_DATA/8-1:0] o_mem_be,
    output logic [NB_ADDR-1:0]   o_mem_addr,
    output logic [NB_DATA-1:0]   o_mem_wdata,
    input  logic [NB_DATA-1:0]   i_mem_rdata,
    input  logic                 i_mem_ack,
    output logic                 o_stall,
    output logic                 o_misaligned,
    output logic                 o_bus_error,
    output logic [NB_DATA-1:0]   o_reg_read,
    output logic [NB_DATA-1:0]   o_ALUresult,
    output logic [NB_REG-1:0]    o_reg2write,
    output logic                 o_mem2reg,
    output logic                 o_regWrite
);

    localparam int NB_BYTES = NB_DATA / 8;
    localparam int OFF_W    = $clog2(NB_BYTES);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state;
    state_t               state_next;

    logic [OFF_W-1:0]     offset;
    logic [NB_ADDR-1:0]   word_addr;
    logic                 mem_access;
    logic                 misaligned_cond;
    logic                 misaligned_hit;
    logic                 start;
    logic                 done;
    logic                 abort;
    logic                 timeout;

    logic [NB_BYTES-1:0]  store_be;
    logic [NB_DATA-1:0]   store_data;

    logic [1:0]           lat_width;
    logic                 lat_sign;
    logic [OFF_W-1:0]     lat_off;
    logic                 lat_read;
    logic [NB_DATA-1:0]   lat_result;
    logic [NB_REG-1:0]    lat_reg;
    logic                 lat_mem2reg;
    logic                 lat_regwrite;

    logic [NB_DATA-1:0]   shifted;
    logic [NB_DATA-1:0]   load_val;

    assign offset     = i_result[OFF_W-1:0];
    assign word_addr  = i_result[OFF_W +: NB_ADDR];
    assign mem_access = i_memRead | i_memWrite;

    // Dword accesses have no legal encoding on a 32-bit bus.
    always_comb begin
        misaligned_cond = 1'b0;
        case (i_width)
            2'b00:   misaligned_cond = 1'b0;
            2'b01:   misaligned_cond = offset[0];
            2'b10:   misaligned_cond = (offset[1:0] != 2'b00);
            default: misaligned_cond = (NB_DATA == 32) || (offset != '0);
        endcase
    end

    assign start          = (state == IDLE) & ~i_halt & mem_access & ~misaligned_cond;
    assign misaligned_hit = (state == IDLE) & ~i_halt & mem_access &  misaligned_cond;
    assign done           = (state == BUSY) & (i_mem_ack | timeout);
    assign abort          = timeout & ~i_mem_ack;

    assign o_mem_req = (state == BUSY);
    assign o_stall   = i_reset & (start | ((state == BUSY) & ~done));

    always_comb begin
        store_be   = '1;
        store_data = i_data4Mem;
        case (i_width)
            2'b00: begin
                store_data = {NB_BYTES{i_data4Mem[7:0]}};
                store_be   = NB_BYTES'(1) << offset;
            end
            2'b01: begin
                store_data = {(NB_BYTES/2){i_data4Mem[15:0]}};
                store_be   = NB_BYTES'(3) << offset;
            end
            2'b10: begin
                store_data = {(NB_BYTES/4){i_data4Mem[31:0]}};
                store_be   = NB_BYTES'(15) << offset;
            end
            default: begin
                store_data = i_data4Mem;
                store_be   = '1;
            end
        endcase
        if (!i_memWrite) begin
            store_be = '1;
        end
    end

    // Load data is aligned down to lane 0, then truncated and extended.
    always_comb begin
        shifted  = i_mem_rdata >> {lat_off, 3'b000};
        load_val = shifted;
        case (lat_width)
            2'b00:   load_val = lat_sign ? NB_DATA'($signed(shifted[7:0]))  : NB_DATA'(shifted[7:0]);
            2'b01:   load_val = lat_sign ? NB_DATA'($signed(shifted[15:0])) : NB_DATA'(shifted[15:0]);
            2'b10:   load_val = lat_sign ? NB_DATA'($signed(shifted[31:0])) : NB_DATA'(shifted[31:0]);
            default: load_val = shifted;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (done)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] busy_cnt;

    assign timeout = (state == BUSY) & (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            busy_cnt    <= '0;
            o_bus_error <= 1'b0;
        end else begin
            if (start) begin
                busy_cnt <= '0;
            end else if (state == BUSY) begin
                busy_cnt <= busy_cnt + CNT_W'(1);
            end
            if (abort) begin
                o_bus_error <= 1'b1;
            end
        end
    end
`else
    assign timeout     = 1'b0;
    assign o_bus_error = 1'b0;
`endif

    // The whole request is captured on entry to BUSY so the bus stays stable.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            o_mem_we     <= 1'b0;
            o_mem_be     <= '0;
            o_mem_addr   <= '0;
            o_mem_wdata  <= '0;
            lat_width    <= '0;
            lat_sign     <= 1'b0;
            lat_off      <= '0;
            lat_read     <= 1'b0;
            lat_result   <= '0;
            lat_reg      <= '0;
            lat_mem2reg  <= 1'b0;
            lat_regwrite <= 1'b0;
        end else if (start) begin
            o_mem_we     <= i_memWrite;
            o_mem_be     <= store_be;
            o_mem_addr   <= word_addr;
            o_mem_wdata  <= store_data;
            lat_width    <= i_width;
            lat_sign     <= i_sign_flag;
            lat_off      <= offset;
            lat_read     <= i_memRead;
            lat_result   <= i_result;
            lat_reg      <= i_reg2write;
            lat_mem2reg  <= i_mem2reg;
            lat_regwrite <= i_regWrite;
        end
    end

    // MEM/WB: bubbles while stalled or faulted, frozen by halt only when idle.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            o_reg_read   <= '0;
            o_ALUresult  <= '0;
            o_reg2write  <= '0;
            o_mem2reg    <= 1'b0;
            o_regWrite   <= 1'b0;
            o_misaligned <= 1'b0;
        end else begin
            o_misaligned <= misaligned_hit;
            if (state == BUSY) begin
                if (done && !abort) begin
                    if (lat_read) begin
                        o_reg_read <= load_val;
                    end
                    o_ALUresult <= lat_result;
                    o_reg2write <= lat_reg;
                    o_mem2reg   <= lat_mem2reg;
                    o_regWrite  <= lat_regwrite;
                end else begin
                    o_mem2reg  <= 1'b0;
                    o_regWrite <= 1'b0;
                end
            end else if (!i_halt) begin
                if (start || misaligned_hit) begin
                    o_mem2reg  <= 1'b0;
                    o_regWrite <= 1'b0;
                end else begin
                    o_ALUresult <= i_result;
                    o_reg2write <= i_reg2write;
                    o_mem2reg   <= i_mem2reg;
                    o_regWrite  <= i_regWrite;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_bus.sv
// Directed self-checking bench for mem_stage_bus on a 32-bit bus.
// Define MEM_TIMEOUT_EN for both files to include the watchdog steps.
module tb_mem_stage_bus;

    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 8;
    localparam int NB_REG  = 5;

    logic                 clk;
    logic                 i_reset;
    logic                 i_halt;
    logic [NB_DATA-1:0]   i_result;
    logic [NB_DATA-1:0]   i_data4Mem;
    logic [NB_REG-1:0]    i_reg2write;
    logic [1:0]           i_width;
    logic                 i_sign_flag;
    logic                 i_memRead;
    logic                 i_memWrite;
    logic                 i_mem2reg;
    logic                 i_regWrite;
    logic                 o_mem_req;
    logic                 o_mem_we;
    logic [NB_DATA/8-1:0] o_mem_be;
    logic [NB_ADDR-1:0]   o_mem_addr;
    logic [NB_DATA-1:0]   o_mem_wdata;
    logic [NB_DATA-1:0]   i_mem_rdata;
    logic                 i_mem_ack;
    logic                 o_stall;
    logic                 o_misaligned;
    logic                 o_bus_error;
    logic [NB_DATA-1:0]   o_reg_read;
    logic [NB_DATA-1:0]   o_ALUresult;
    logic [NB_REG-1:0]    o_reg2write;
    logic                 o_mem2reg;
    logic                 o_regWrite;

    int passed = 0;
    int total  = 0;

    mem_stage_bus #(
        .NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_REG(NB_REG), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .i_reset(i_reset), .i_halt(i_halt),
        .i_result(i_result), .i_data4Mem(i_data4Mem), .i_reg2write(i_reg2write),
        .i_width(i_width), .i_sign_flag(i_sign_flag),
        .i_memRead(i_memRead), .i_memWrite(i_memWrite),
        .i_mem2reg(i_mem2reg), .i_regWrite(i_regWrite),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
        .o_stall(o_stall), .o_misaligned(o_misaligned), .o_bus_error(o_bus_error),
        .o_reg_read(o_reg_read), .o_ALUresult(o_ALUresult), .o_reg2write(o_reg2write),
        .o_mem2reg(o_mem2reg), .o_regWrite(o_regWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [31:0] result, input logic [31:0] data,
                                 input logic [4:0] rdst, input logic [1:0] width,
                                 input logic sgn, input logic rd, input logic wr,
                                 input logic m2r, input logic rw);
        i_result    = result;
        i_data4Mem  = data;
        i_reg2write = rdst;
        i_width     = width;
        i_sign_flag = sgn;
        i_memRead   = rd;
        i_memWrite  = wr;
        i_mem2reg   = m2r;
        i_regWrite  = rw;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    // Inputs change 1 time unit after the active edge, well away from it.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        i_reset     = 1'b0;
        i_halt      = 1'b0;
        i_mem_ack   = 1'b0;
        i_mem_rdata = '0;
        applyStimulus(32'h0, 32'h0, 5'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_req",    o_mem_req,    0);
        checkOutput("rst_stall",  o_stall,      0);
        checkOutput("rst_regw",   o_regWrite,   0);
        checkOutput("rst_alu",    o_ALUresult,  0);
        checkOutput("rst_mis",    o_misaligned, 0);
        checkOutput("rst_buserr", o_bus_error,  0);
        nextCycle();
        i_reset = 1'b1;

        // Non-memory op passes straight through, then halt freezes MEM/WB.
        applyStimulus(32'h12345678, 32'h0, 5'd7, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("nop_stall", o_stall, 0);
        nextCycle();
        checkOutput("nop_alu",  o_ALUresult, 32'h12345678);
        checkOutput("nop_reg",  o_reg2write, 7);
        checkOutput("nop_regw", o_regWrite,  1);
        checkOutput("nop_req",  o_mem_req,   0);
        i_halt = 1'b1;
        applyStimulus(32'hDEADBEEF, 32'h0, 5'd9, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        checkOutput("halt_alu",  o_ALUresult, 32'h12345678);
        checkOutput("halt_reg",  o_reg2write, 7);
        checkOutput("halt_regw", o_regWrite,  1);

        // Store byte 0xA5 at 0x13, ack in the third BUSY cycle.
        i_halt = 1'b0;
        applyStimulus(32'h13, 32'hA5, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("sb_stall0", o_stall,   1);
        checkOutput("sb_req0",   o_mem_req, 0);
        nextCycle();
        checkOutput("sb_req",    o_mem_req,   1);
        checkOutput("sb_we",     o_mem_we,    1);
        checkOutput("sb_wdata",  o_mem_wdata, 32'hA5A5A5A5);
        checkOutput("sb_be",     o_mem_be,    4'b1000);
        checkOutput("sb_addr",   o_mem_addr,  8'h04);
        checkOutput("sb_stall1", o_stall,     1);
        checkOutput("sb_bubble", o_regWrite,  0);
        nextCycle();
        checkOutput("sb_stall2", o_stall,     1);
        checkOutput("sb_hold",   o_mem_wdata, 32'hA5A5A5A5);
        nextCycle();
        i_mem_ack = 1'b1;
        #1;
        checkOutput("sb_stall3", o_stall, 0);
        nextCycle();
        i_mem_ack = 1'b0;
        applyStimulus(32'h0, 32'h0, 5'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("sb_done_req",  o_mem_req,   0);
        checkOutput("sb_done_regw", o_regWrite,  0);
        checkOutput("sb_done_alu",  o_ALUresult, 32'h13);

        // Store half 0xBEEF at 0x1E, ack in the first BUSY cycle.
        applyStimulus(32'h1E, 32'h0000BEEF, 5'd0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        nextCycle();
        checkOutput("sh_wdata", o_mem_wdata, 32'hBEEFBEEF);
        checkOutput("sh_be",    o_mem_be,    4'b1100);
        checkOutput("sh_addr",  o_mem_addr,  8'h07);
        i_mem_ack = 1'b1;
        #1;
        checkOutput("sh_stall", o_stall, 0);
        nextCycle();
        i_mem_ack = 1'b0;
        applyStimulus(32'h0, 32'h0, 5'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Signed then unsigned halfword load from 0x22.
        applyStimulus(32'h22, 32'h0, 5'd3, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("lhs_stall0", o_stall, 1);
        nextCycle();
        checkOutput("lhs_be",   o_mem_be,   4'b1111);
        checkOutput("lhs_addr", o_mem_addr, 8'h08);
        checkOutput("lhs_we",   o_mem_we,   0);
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'h80010000;
        #1;
        checkOutput("lhs_stall1", o_stall, 0);
        nextCycle();
        i_mem_ack = 1'b0;
        applyStimulus(32'h0, 32'h0, 5'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lhs_data", o_reg_read,  32'hFFFF8001);
        checkOutput("lhs_regw", o_regWrite,  1);
        checkOutput("lhs_m2r",  o_mem2reg,   1);
        checkOutput("lhs_reg",  o_reg2write, 3);
        applyStimulus(32'h22, 32'h0, 5'd4, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        nextCycle();
        i_mem_ack = 1'b1;
        nextCycle();
        i_mem_ack = 1'b0;
        applyStimulus(32'h0, 32'h0, 5'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lhu_data", o_reg_read,  32'h00008001);
        checkOutput("lhu_reg",  o_reg2write, 4);

        // Misaligned word load, then a dword store that cannot exist on 32 bits.
        applyStimulus(32'h06, 32'h0, 5'd2, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("mis_stall", o_stall, 0);
        nextCycle();
        checkOutput("mis_pulse", o_misaligned, 1);
        checkOutput("mis_req",   o_mem_req,    0);
        checkOutput("mis_regw",  o_regWrite,   0);
        applyStimulus(32'h40, 32'h0, 5'd0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("mis_d_stall", o_stall, 0);
        nextCycle();
        checkOutput("mis_d_pulse", o_misaligned, 1);
        checkOutput("mis_d_req",   o_mem_req,    0);
        applyStimulus(32'h55, 32'h0, 5'd5, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        nextCycle();
        checkOutput("mis_end",    o_misaligned, 0);
        checkOutput("mis_after",  o_regWrite,   1);

        // Halt raised in BUSY: the load completes, then MEM/WB freezes.
        applyStimulus(32'h10, 32'h0, 5'd6, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        nextCycle();
        i_halt = 1'b1;
        #1;
        checkOutput("hb_req", o_mem_req, 1);
        nextCycle();
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'hCAFEF00D;
        #1;
        checkOutput("hb_stall", o_stall, 0);
        nextCycle();
        i_mem_ack = 1'b0;
        applyStimulus(32'h99, 32'h0, 5'd9, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("hb_data", o_reg_read,  32'hCAFEF00D);
        checkOutput("hb_regw", o_regWrite,  1);
        checkOutput("hb_reg",  o_reg2write, 6);
        checkOutput("hb_idle", o_mem_req,   0);
        nextCycle();
        checkOutput("hb_frz_reg", o_reg2write, 6);
        checkOutput("hb_frz_alu", o_ALUresult, 32'h10);
        i_halt = 1'b0;

        // A stray ack while idle starts nothing.
        applyStimulus(32'h77, 32'h0, 5'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        i_mem_ack = 1'b1;
        nextCycle();
        checkOutput("ack_idle_req",   o_mem_req, 0);
        checkOutput("ack_idle_stall", o_stall,   0);
        i_mem_ack = 1'b0;

`ifdef MEM_TIMEOUT_EN
        // No ack ever: abort after the fourth BUSY cycle.
        applyStimulus(32'h30, 32'h1, 5'd0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        nextCycle();
        checkOutput("to_stall1", o_stall, 1);
        nextCycle();
        nextCycle();
        checkOutput("to_stall3", o_stall, 1);
        nextCycle();
        checkOutput("to_stall4", o_stall, 0);
        nextCycle();
        applyStimulus(32'h77, 32'h0, 5'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("to_req",  o_mem_req,   0);
        checkOutput("to_err",  o_bus_error, 1);
        checkOutput("to_regw", o_regWrite,  0);
        nextCycle();
        checkOutput("to_sticky", o_bus_error, 1);
`else
        checkOutput("no_buserr", o_bus_error, 0);
`endif

        // Reset while BUSY drops the request and clears outputs at once.
        applyStimulus(32'h20, 32'h11223344, 5'd0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("rb_stall0", o_stall, 1);
        nextCycle();
        checkOutput("rb_req",   o_mem_req,   1);
        checkOutput("rb_wdata", o_mem_wdata, 32'h11223344);
        checkOutput("rb_be",    o_mem_be,    4'b1111);
        checkOutput("rb_addr",  o_mem_addr,  8'h08);
        checkOutput("rb_alu0",  o_ALUresult, 32'h77);
        #2;
        i_reset = 1'b0;
        #1;
        checkOutput("rb_req0",   o_mem_req,   0);
        checkOutput("rb_stall",  o_stall,     0);
        checkOutput("rb_we",     o_mem_we,    0);
        checkOutput("rb_be0",    o_mem_be,    0);
        checkOutput("rb_alu",    o_ALUresult, 0);
        checkOutput("rb_buserr", o_bus_error, 0);
        nextCycle();
        i_reset = 1'b1;
        nextCycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_stage_bus.md
Name: mem_stage_bus

Overview:
- Next-generation MEM stage of the pipelined MIPS core, sitting between EX/MEM and writeback.
- Replaces the fixed single-cycle RAM access with a req/ack bus master to an external data memory of arbitrary latency.
- Adds byte-lane stores, offset-aware sign/zero-extended loads, misalignment detection, a pipeline stall output and an integrated MEM/WB register.

Parameters:
- NB_DATA, 32, data/bus width; legal values 32 or 64.
- NB_ADDR, 8, word-address width on the memory bus.
- NB_REG, 5, register-index width.
- TIMEOUT_CYCLES, 64, watchdog limit; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- i_reset  in  1  asynchronous active-low reset.
- i_halt  in  1  freeze MEM/WB; sampled only in IDLE.
- i_result  in  NB_DATA  ALU result / byte address.
- i_data4Mem  in  NB_DATA  store source data.
- i_reg2write  in  NB_REG  destination register.
- i_width  in  2  00 byte, 01 half, 10 word, 11 dword (64-bit only).
- i_sign_flag  in  1  1 = sign-extend load, 0 = zero-extend.
- i_memRead, i_memWrite, i_mem2reg, i_regWrite  in  1 each  control.
- o_mem_req  out  1  bus request, held until ack.
- o_mem_we  out  1  write strobe.
- o_mem_be  out  NB_DATA/8  byte enables.
- o_mem_addr  out  NB_ADDR  word address.
- o_mem_wdata  out  NB_DATA  lane-replicated store data.
- i_mem_rdata  in  NB_DATA  read data, valid with ack.
- i_mem_ack  in  1  transaction complete.
- o_stall  out  1  hold IF/ID/EX/MEM.
- o_misaligned  out  1  one-cycle pulse on misaligned access.
- o_bus_error  out  1  sticky timeout flag (MEM_TIMEOUT_EN only; otherwise tied 0).
- o_reg_read, o_ALUresult  out  NB_DATA  MEM/WB payload.
- o_reg2write  out  NB_REG  MEM/WB payload.
- o_mem2reg, o_regWrite  out  1  MEM/WB control.

Behaviour:
- Reset (i_reset=0, async): all outputs 0, FSM in IDLE, MEM/WB cleared.
- Byte offset is i_result[log2(NB_DATA/8)-1:0]; word address is the next NB_ADDR bits.
- Misaligned access:
  - Condition: half with offset[0]≠0, word with offset[1:0]≠0, or dword with offset≠0.
  - Also width 11 when NB_DATA=32.
  - Response: no bus request, o_misaligned pulses 1 cycle, MEM/WB loads a bubble (o_regWrite=0).
- FSM states:
  - IDLE: an aligned access (memRead|memWrite) asserts o_stall combinationally. Next edge latches addr/we/be/wdata and enters BUSY. Non-memory ops pass straight to MEM/WB with no stall.
  - BUSY: o_mem_req=1; bus outputs held stable. On i_mem_ack, o_stall drops in the same cycle, load data is extracted, MEM/WB loads, and the FSM returns to IDLE.
- Minimum access cost is 1 stall cycle (ack in the first BUSY cycle). Back-to-back accesses re-enter BUSY via IDLE.
- Store lanes:
  - Byte data is replicated to all lanes; be = 1<<offset.
  - Half: be = 2'b11<<offset.
  - Word/dword: the corresponding enables.
  - Loads drive be = all-ones.
- Load extract: rdata >> (8*offset), truncated to width, then sign- or zero-extended per i_sign_flag.
- MEM/WB update rules:
  - Loads when ~i_halt & ~o_stall.
  - Loads a bubble (regWrite=0, mem2reg=0, payload held) while stalled.
  - Holds entirely while i_halt is 1.
- i_halt arriving during BUSY is ignored until the ack returns the FSM to IDLE; an outstanding transaction is never abandoned.
- Reset mid-BUSY drops o_mem_req immediately (async) and discards the transaction.
- An ack in IDLE is ignored.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in BUSY.
  - When it reaches TIMEOUT_CYCLES without ack: abort to IDLE, drop req, set o_bus_error sticky until reset, load a bubble into MEM/WB, release stall.
- Without the macro: no counter, BUSY waits indefinitely, o_bus_error tied 0.

Test Plan:
- Store byte 0xA5 to address 0x13 with ack after 3 cycles -> wdata 0xA5A5A5A5, be 4'b1000, addr 0x04; o_stall high for 3 cycles; no regWrite.
- Load half signed from 0x22 with rdata 0x8001_0000 -> o_reg_read 0xFFFF8001; unsigned -> 0x00008001.
- Load word from 0x06 -> o_misaligned pulses, o_mem_req stays 0, o_regWrite 0, o_stall 0.
- Non-memory op with regWrite=1 -> MEM/WB loads next edge, zero stall; i_halt=1 then freezes all MEM/WB outputs.
- i_halt asserted in BUSY, ack 2 cycles later -> transaction completes, then MEM/WB freezes; async reset in BUSY drops req and all outputs within the same cycle.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never arrives -> abort after 4 BUSY cycles, o_bus_error=1 and sticky, o_stall released, bubble written.
